// File: rtl/serv_dbg_pkg.sv
// rtl/serv_dbg_pkg.sv - shared encodings for the SERV debug controller
// Opcodes, FSM states, halt causes, status-word layout and the status packer.
package serv_dbg_pkg;

  typedef enum logic [2:0] {
    ST_RUN      = 3'd0,
    ST_HALT_REQ = 3'd1,
    ST_HALTED   = 3'd2,
    ST_STEP     = 3'd3,
    ST_RST      = 3'd4
  } dbg_state_e;

  typedef enum logic [2:0] {
    OP_STATUS = 3'd0,
    OP_HALT   = 3'd1,
    OP_RESUME = 3'd2,
    OP_STEP   = 3'd3,
    OP_RESET  = 3'd4,
    OP_SET_BP = 3'd5,
    OP_CLR_BP = 3'd6,
    OP_COUNT  = 3'd7
  } dbg_op_e;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_CMD     = 2'd1,
    CAUSE_BP      = 2'd2,
    CAUSE_TIMEOUT = 2'd3
  } dbg_cause_e;

  localparam int STAT_STATE_LSB = 0;
  localparam int STAT_BP_EN_BIT = 3;
  localparam int STAT_CAUSE_LSB = 4;

  function automatic logic [31:0] status_word(input dbg_state_e st, input logic bp_en,
                                              input dbg_cause_e cause);
    logic [31:0] w;
    w = '0;
    w[STAT_STATE_LSB +: 3] = st;
    w[STAT_BP_EN_BIT]      = bp_en;
    w[STAT_CAUSE_LSB +: 2] = cause;
    return w;
  endfunction

endpackage

// File: rtl/serv_dbg_bp.sv
// rtl/serv_dbg_bp.sv - breakpoint address register and comparator
// Only instantiated when SERV_DBG_BREAKPOINT_EN is defined.
module serv_dbg_bp (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        set,
  input  logic        clr,
  input  logic [31:0] arg,
  input  logic [31:0] adr,
  output logic        bp_en,
  output logic        match
);

  logic [31:0] bp_adr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bp_adr <= '0;
      bp_en  <= 1'b0;
    end else if (set) begin
      bp_adr <= arg;
      bp_en  <= 1'b1;
    end else if (clr) begin
      bp_en  <= 1'b0;
    end
  end

  assign match = bp_en && (adr == bp_adr);

endmodule

// File: rtl/serv_dbg_ctrl.sv
// rtl/serv_dbg_ctrl.sv - SERV debug controller: halt/resume/step/reset FSM and fetch counter
// Breakpoint support is built only when SERV_DBG_BREAKPOINT_EN is defined.
module serv_dbg_ctrl #(
  parameter int RESET_CYCLES = 4,
  parameter int HALT_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        i_rst_n,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic [2:0]  i_cmd_op,
  input  logic [31:0] i_cmd_arg,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_data,
  input  logic [31:0] i_ibus_adr,
  input  logic        i_ibus_cyc,
  input  logic        i_ibus_ack,
  input  logic        i_dbg_process,
  output logic        o_dbg_halt,
  output logic        o_dbg_reset,
  output logic        o_halted
);
  import serv_dbg_pkg::*;

  localparam int RST_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int TMO_W = (HALT_TIMEOUT > 1) ? $clog2(HALT_TIMEOUT) : 1;
  localparam logic [RST_W-1:0] RST_LAST = RST_W'(RESET_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(HALT_TIMEOUT - 1);

  dbg_state_e       state, state_d, ret_state, ret_state_d;
  dbg_cause_e       cause, cause_d;
  logic [31:0]      fetch_cnt, fetch_cnt_d;
  logic [TMO_W-1:0] tmo_cnt, tmo_cnt_d;
  logic [RST_W-1:0] rst_cnt, rst_cnt_d;
  logic             halt_d, reset_d;
  logic             cmd_set, cmd_clr;
  logic             bp_en, bp_en_nx, bp_match, bp_hit;
  logic [31:0]      rsp_data_d;
  dbg_op_e          op;
  logic             fetch, cmd_acc;

  assign op          = dbg_op_e'(i_cmd_op);
  assign fetch       = i_ibus_cyc && i_ibus_ack;
  assign o_cmd_ready = ((state == ST_RUN) || (state == ST_HALTED)) && !o_rsp_valid;
  assign cmd_acc     = i_cmd_valid && o_cmd_ready;
  assign bp_hit      = (state == ST_RUN) && fetch && bp_match;
  assign o_halted    = (state == ST_HALTED);

`ifdef SERV_DBG_BREAKPOINT_EN
  serv_dbg_bp u_bp (
    .clk   (clk),
    .rst_n (i_rst_n),
    .set   (cmd_set),
    .clr   (cmd_clr),
    .arg   (i_cmd_arg),
    .adr   (i_ibus_adr),
    .bp_en (bp_en),
    .match (bp_match)
  );
  assign bp_en_nx = cmd_set ? 1'b1 : (cmd_clr ? 1'b0 : bp_en);
`else
  logic unused_bp;
  assign bp_en     = 1'b0;
  assign bp_match  = 1'b0;
  assign bp_en_nx  = 1'b0;
  assign unused_bp = ^{i_cmd_arg, i_ibus_adr, cmd_set, cmd_clr, bp_en};
`endif

  always_comb begin
    state_d     = state;
    ret_state_d = ret_state;
    cause_d     = cause;
    halt_d      = o_dbg_halt;
    reset_d     = o_dbg_reset;
    tmo_cnt_d   = tmo_cnt;
    rst_cnt_d   = rst_cnt;
    cmd_set     = 1'b0;
    cmd_clr     = 1'b0;
    fetch_cnt_d = (fetch && state != ST_RST) ? fetch_cnt + 32'd1 : fetch_cnt;

    case (state)
      ST_RUN, ST_HALTED: begin
        // A breakpoint hit overrides whatever command lands in the same cycle.
        if (bp_hit) begin
          state_d   = ST_HALT_REQ;
          halt_d    = 1'b1;
          cause_d   = CAUSE_BP;
          tmo_cnt_d = '0;
        end else if (cmd_acc) begin
          case (op)
            OP_HALT: if (state == ST_RUN) begin
              state_d   = ST_HALT_REQ;
              halt_d    = 1'b1;
              cause_d   = CAUSE_CMD;
              tmo_cnt_d = '0;
            end
            OP_RESUME: if (state == ST_HALTED) begin
              state_d = ST_RUN;
              halt_d  = 1'b0;
              cause_d = CAUSE_NONE;
            end
            OP_STEP: if (state == ST_HALTED) begin
              state_d = ST_STEP;
              halt_d  = 1'b0;
            end
            OP_RESET: begin
              state_d     = ST_RST;
              ret_state_d = state;
              reset_d     = 1'b1;
              rst_cnt_d   = '0;
            end
            OP_SET_BP: cmd_set = 1'b1;
            OP_CLR_BP: cmd_clr = 1'b1;
            default: ;
          endcase
        end
      end
      ST_HALT_REQ: begin
        if (i_dbg_process) begin
          state_d = ST_HALTED;
        end else if (tmo_cnt == TMO_LAST) begin
          state_d = ST_HALTED;
          cause_d = CAUSE_TIMEOUT;
        end else begin
          tmo_cnt_d = tmo_cnt + 1'b1;
        end
      end
      ST_STEP: begin
        if (fetch) begin
          state_d   = ST_HALT_REQ;
          halt_d    = 1'b1;
          tmo_cnt_d = '0;
        end
      end
      ST_RST: begin
        if (rst_cnt == RST_LAST) begin
          state_d     = ret_state;
          reset_d     = 1'b0;
          fetch_cnt_d = '0;
        end else begin
          rst_cnt_d = rst_cnt + 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // The response reflects the state as it will be after this edge.
  assign rsp_data_d = (op == OP_COUNT) ? fetch_cnt_d : status_word(state_d, bp_en_nx, cause_d);

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= ST_RUN;
      ret_state   <= ST_RUN;
      cause       <= CAUSE_NONE;
      fetch_cnt   <= '0;
      tmo_cnt     <= '0;
      rst_cnt     <= '0;
      o_dbg_halt  <= 1'b0;
      o_dbg_reset <= 1'b0;
      o_rsp_valid <= 1'b0;
      o_rsp_data  <= '0;
    end else begin
      state       <= state_d;
      ret_state   <= ret_state_d;
      cause       <= cause_d;
      fetch_cnt   <= fetch_cnt_d;
      tmo_cnt     <= tmo_cnt_d;
      rst_cnt     <= rst_cnt_d;
      o_dbg_halt  <= halt_d;
      o_dbg_reset <= reset_d;
      o_rsp_valid <= cmd_acc;
      if (cmd_acc) o_rsp_data <= rsp_data_d;
    end
  end

endmodule

// File: tb/tb_serv_dbg_ctrl.sv
// tb/tb_serv_dbg_ctrl.sv - directed self-checking bench for serv_dbg_ctrl
// Breakpoint expectations follow SERV_DBG_BREAKPOINT_EN.
module tb_serv_dbg_ctrl;

  localparam logic [2:0] C_STATUS = 3'd0, C_HALT = 3'd1, C_RESUME = 3'd2, C_STEP = 3'd3,
                         C_RESET = 3'd4, C_SET_BP = 3'd5, C_CLR_BP = 3'd6, C_COUNT = 3'd7;

  logic        clk = 1'b0;
  logic        i_rst_n, i_cmd_valid, o_cmd_ready, o_rsp_valid;
  logic [2:0]  i_cmd_op;
  logic [31:0] i_cmd_arg, o_rsp_data, i_ibus_adr;
  logic        i_ibus_cyc, i_ibus_ack, i_dbg_process, o_dbg_halt, o_dbg_reset, o_halted;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] d;

  always #5 clk = ~clk;

  serv_dbg_ctrl #(.RESET_CYCLES(4), .HALT_TIMEOUT(8)) dut (
    .clk(clk), .i_rst_n(i_rst_n), .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_op(i_cmd_op), .i_cmd_arg(i_cmd_arg), .o_rsp_valid(o_rsp_valid),
    .o_rsp_data(o_rsp_data), .i_ibus_adr(i_ibus_adr), .i_ibus_cyc(i_ibus_cyc),
    .i_ibus_ack(i_ibus_ack), .i_dbg_process(i_dbg_process), .o_dbg_halt(o_dbg_halt),
    .o_dbg_reset(o_dbg_reset), .o_halted(o_halted)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called on a falling edge; returns on the falling edge right after acceptance.
  task automatic send(input logic [2:0] op, input logic [31:0] arg, output logic [31:0] data);
    int n = 0;
    i_cmd_op = op; i_cmd_arg = arg; i_cmd_valid = 1'b1;
    while (!o_cmd_ready && n < 50) begin @(negedge clk); n++; end
    if (!o_cmd_ready) check("cmd_ready_wait", 32'd0, 32'd1);
    @(negedge clk);
    i_cmd_valid = 1'b0;
    check("rsp_valid", {31'd0, o_rsp_valid}, 32'd1);
    data = o_rsp_data;
  endtask

  task automatic fetch(input logic [31:0] adr);
    i_ibus_adr = adr; i_ibus_cyc = 1'b1; i_ibus_ack = 1'b1;
    @(negedge clk);
    i_ibus_cyc = 1'b0; i_ibus_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, hi, drop;
    i_rst_n = 1'b0; i_cmd_valid = 1'b0; i_cmd_op = '0; i_cmd_arg = '0;
    i_ibus_adr = '0; i_ibus_cyc = 1'b0; i_ibus_ack = 1'b0; i_dbg_process = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_halt", {31'd0, o_dbg_halt}, 32'd0);
    check("rst_reset", {31'd0, o_dbg_reset}, 32'd0);
    check("rst_halted", {31'd0, o_halted}, 32'd0);
    check("rst_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
    check("rst_rsp_data", o_rsp_data, 32'd0);
    check("rst_ready", {31'd0, o_cmd_ready}, 32'd1);
    i_rst_n = 1'b1;
    @(negedge clk);
    send(C_STATUS, 0, d); check("status_reset", d, 32'h0);
    send(C_COUNT, 0, d);  check("count_reset", d, 32'h0);

    fetch(32'h10); fetch(32'h14); fetch(32'h18);
    send(C_COUNT, 0, d);  check("count_3", d, 32'd3);
    send(C_RESUME, 0, d); check("resume_in_run", d, 32'h0);
    send(C_STEP, 0, d);   check("step_in_run", d, 32'h0);

    // HALT, acknowledge raised three clocks after the halt request
    send(C_HALT, 0, d);   check("halt_rsp", d, 32'h11);
    check("halt_asserted", {31'd0, o_dbg_halt}, 32'd1);
    check("halted_e0", {31'd0, o_halted}, 32'd0);
    repeat (3) @(negedge clk);
    check("halted_e3", {31'd0, o_halted}, 32'd0);
    i_dbg_process = 1'b1;
    @(negedge clk);
    check("halted_e4", {31'd0, o_halted}, 32'd1);
    send(C_STATUS, 0, d); check("status_halted", d, 32'h12);
    send(C_HALT, 0, d);   check("halt_in_halted", d, 32'h12);

    // single step
    i_dbg_process = 1'b0;
    send(C_STEP, 0, d);   check("step_rsp", d, 32'h13);
    check("step_halt_low", {31'd0, o_dbg_halt}, 32'd0);
    @(negedge clk);
    check("step_wait_halt_low", {31'd0, o_dbg_halt}, 32'd0);
    fetch(32'h20);
    check("step_halt_again", {31'd0, o_dbg_halt}, 32'd1);
    i_dbg_process = 1'b1;
    @(negedge clk);
    i_dbg_process = 1'b0;
    check("step_halted", {31'd0, o_halted}, 32'd1);
    send(C_COUNT, 0, d);  check("count_after_step", d, 32'd4);

    // core reset from HALTED
    send(C_RESET, 0, d);  check("reset_rsp", d, 32'h14);
    hi = 0; drop = 0;
    for (int i = 0; i < 8; i++) begin
      if (o_dbg_reset) hi++;
      if (!o_dbg_halt) drop++;
      @(negedge clk);
    end
    check("reset_len", hi, 32'd4);
    check("reset_halt_held", drop, 32'd0);
    check("reset_back_halted", {31'd0, o_halted}, 32'd1);
    send(C_STATUS, 0, d); check("status_after_reset", d, 32'h12);
    send(C_COUNT, 0, d);  check("count_after_reset", d, 32'd0);
    send(C_RESUME, 0, d); check("resume_rsp", d, 32'h0);
    check("resume_halt_low", {31'd0, o_dbg_halt}, 32'd0);

    // halt acknowledge never comes
    send(C_HALT, 0, d);   check("halt2_rsp", d, 32'h11);
    k = 0;
    while (!o_halted && k < 20) begin @(negedge clk); k++; end
    check("timeout_clocks", k, 32'd8);
    send(C_STATUS, 0, d); check("status_timeout", d, 32'h32);
    send(C_RESUME, 0, d); check("resume2_rsp", d, 32'h0);

    // breakpoint
    send(C_SET_BP, 32'h100, d);
`ifdef SERV_DBG_BREAKPOINT_EN
    check("set_bp_rsp", d, 32'h08);
    fetch(32'h0FC);
    check("bp_miss", {31'd0, o_dbg_halt}, 32'd0);
    fetch(32'h100);
    check("bp_hit_halt", {31'd0, o_dbg_halt}, 32'd1);
    i_dbg_process = 1'b1;
    @(negedge clk);
    i_dbg_process = 1'b0;
    send(C_STATUS, 0, d); check("status_bp", d, 32'h2A);
    send(C_RESUME, 0, d); check("resume_bp", d, 32'h08);
    // command and breakpoint hit in the same cycle
    i_cmd_op = C_HALT; i_cmd_valid = 1'b1;
    i_ibus_adr = 32'h100; i_ibus_cyc = 1'b1; i_ibus_ack = 1'b1;
    @(negedge clk);
    i_cmd_valid = 1'b0; i_ibus_cyc = 1'b0; i_ibus_ack = 1'b0;
    check("same_cycle_valid", {31'd0, o_rsp_valid}, 32'd1);
    check("same_cycle_data", o_rsp_data, 32'h29);
    i_dbg_process = 1'b1;
    @(negedge clk);
    i_dbg_process = 1'b0;
    send(C_CLR_BP, 0, d); check("clr_bp_rsp", d, 32'h22);
    send(C_RESUME, 0, d); check("resume_clr", d, 32'h0);
`else
    check("set_bp_noop", d, 32'h0);
    fetch(32'h0FC);
    fetch(32'h100);
    @(negedge clk);
    check("bp_absent_halt", {31'd0, o_dbg_halt}, 32'd0);
    send(C_CLR_BP, 0, d); check("clr_bp_noop", d, 32'h0);
`endif

    // asynchronous reset while inside RST
    send(C_HALT, 0, d);   check("halt3_rsp", d, 32'h11);
    i_dbg_process = 1'b1;
    @(negedge clk);
    i_dbg_process = 1'b0;
    send(C_RESET, 0, d);  check("reset2_rsp", d, 32'h14);
    #2 i_rst_n = 1'b0;
    #1;
    check("async_halt", {31'd0, o_dbg_halt}, 32'd0);
    check("async_reset", {31'd0, o_dbg_reset}, 32'd0);
    check("async_halted", {31'd0, o_halted}, 32'd0);
    check("async_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
    check("async_rsp_data", o_rsp_data, 32'h0);
    @(negedge clk);
    i_rst_n = 1'b1;
    @(negedge clk);
    check("no_pending_rsp", {31'd0, o_rsp_valid}, 32'd0);
    check("post_reset_out", {31'd0, o_dbg_reset}, 32'd0);
    send(C_STATUS, 0, d); check("status_post_reset", d, 32'h0);
    send(C_COUNT, 0, d);  check("count_post_reset", d, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serv_dbg_ctrl.md
SERV_DBG_CTRL -- requirements
Module: serv_dbg_ctrl

Interface
REQ-001 SHALL expose parameter RESET_CYCLES, default 4, meaning the o_dbg_reset pulse length in clocks (minimum 1).
REQ-002 SHALL expose parameter HALT_TIMEOUT, default 255, meaning the maximum clocks spent waiting for halt acknowledge.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 i_cmd_valid / o_cmd_ready  in/out  1 each  command handshake; transfer when both are high.
REQ-006 i_cmd_op  input  3  opcode: 0 STATUS, 1 HALT, 2 RESUME, 3 STEP, 4 RESET, 5 SET_BP, 6 CLR_BP, 7 COUNT.
REQ-007 i_cmd_arg  input  32  breakpoint address for SET_BP; ignored for all other opcodes.
REQ-008 o_rsp_valid  output  1  one-cycle response pulse; o_rsp_data  output  32  response word.
REQ-009 i_ibus_adr / i_ibus_cyc / i_ibus_ack  input  32/1/1  snoop of the core instruction bus.
REQ-010 i_dbg_process  input  1  core acknowledge that it is in debug mode.
REQ-011 o_dbg_halt / o_dbg_reset  output  1 each  drive the core i_dbg_halt / i_dbg_reset.
REQ-012 o_halted  output  1  high while in state HALTED.

Function
REQ-013 SHALL use FSM states RUN, HALT_REQ, HALTED, STEP, RST.
REQ-014 o_cmd_ready SHALL be high only in RUN or HALTED and only while o_rsp_valid is low.
REQ-015 Every accepted command SHALL produce exactly one o_rsp_valid pulse on the clock after acceptance.
REQ-016 Status word: [2:0] state encoding, [3] bp_en, [5:4] cause (0 none, 1 cmd, 2 bp, 3 timeout), [31:6] zero.
REQ-017 Response data: COUNT returns the fetch counter; all other opcodes return the status word sampled after the transition.
REQ-018 HALT in RUN: o_dbg_halt asserts next clock; state goes to HALT_REQ; cause=1.
REQ-019 HALT_REQ to HALTED when i_dbg_process=1.
REQ-020 If HALT_TIMEOUT clocks elapse in HALT_REQ without acknowledge, SHALL enter HALTED anyway with cause=3.
REQ-021 RESUME in HALTED: o_dbg_halt deasserts next clock; state goes to RUN; cause=0.
REQ-022 STEP in HALTED: deassert o_dbg_halt; go to STEP; on the first i_ibus_cyc&i_ibus_ack reassert halt and go to HALT_REQ.
REQ-023 RESET in any ready state: o_dbg_reset high for exactly RESET_CYCLES clocks in RST, then return to the originating state.
REQ-024 o_dbg_halt SHALL stay unchanged throughout RST.
REQ-025 SET_BP SHALL load the breakpoint register and set bp_en; CLR_BP SHALL clear bp_en.
REQ-026 Breakpoint hit: in RUN with bp_en, i_ibus_cyc&i_ibus_ack and i_ibus_adr==bp go to HALT_REQ with cause=2.
REQ-027 On a breakpoint hit, o_dbg_halt SHALL assert on the next clock.
REQ-028 If a command acceptance and a breakpoint hit occur in the same cycle, the breakpoint SHALL win; the command still gets its response, evaluated after the breakpoint transition.
REQ-029 Fetch counter: 32-bit, increments on each i_ibus_cyc&i_ibus_ack outside RST, wraps 0xFFFFFFFF to 0.
REQ-030 The fetch counter SHALL clear on RESET completion.
REQ-031 Invalid transitions (HALT when HALTED, RESUME or STEP when RUN) SHALL be a no-op that still returns a status response.

Reset
REQ-032 On i_rst_n low: state RUN; o_dbg_halt, o_dbg_reset, o_halted, o_rsp_valid, bp_en, cause, fetch counter, timeout counter all 0; o_rsp_data 0; breakpoint register 0.
REQ-033 Reset mid-operation (including inside RST or STEP) SHALL abort immediately to the REQ-032 values; no pending response is emitted.

Configuration
REQ-034 Macro SERV_DBG_BREAKPOINT_EN: when defined, the breakpoint register, comparator, and SET_BP/CLR_BP are present.
REQ-035 When SERV_DBG_BREAKPOINT_EN is undefined, SET_BP/CLR_BP SHALL act as status no-ops, bp_en SHALL read 0, and cause=2 SHALL never occur.

Structure
REQ-036 A shared package serv_dbg_pkg SHALL hold the opcode constants, FSM state encoding, cause codes, and status-word bit positions.
REQ-037 A single sub-module serv_dbg_bp (address comparator plus register) is natural; it is instantiated only under SERV_DBG_BREAKPOINT_EN.

Verification
REQ-038 The bench SHALL cover: HALT from RUN with i_dbg_process rising 3 clocks later -> o_dbg_halt=1 after 1 clock; o_halted=1 on the 4th clock; status cause=1.
REQ-039 The bench SHALL cover: SET_BP 0x100, then fetch ack at 0x0FC then 0x100 -> halt on the 0x100 ack +1 clock; cause=2.
REQ-040 The bench SHALL cover: STEP from HALTED, one fetch ack -> halt reasserts after exactly one fetch; fetch counter +1.
REQ-041 The bench SHALL cover: RESET with RESET_CYCLES=4 from HALTED -> o_dbg_reset high exactly 4 clocks, o_dbg_halt held at 1, return to HALTED, COUNT returns 0.
REQ-042 The bench SHALL cover: HALT with i_dbg_process held 0 and HALT_TIMEOUT=8 -> HALTED after 8 clocks with cause=3.
REQ-043 The bench SHALL cover: i_rst_n pulsed low during RST -> all outputs 0 asynchronously and state RUN.
